// File: rtl/mdio_master.sv
// Clause 22 MDIO management master: one register read/write request at a time,
// serialised onto MDC/MDIO through an external tri-state pad buffer.
module mdio_master #(
    parameter int CLK_DIV      = 10,
    parameter int PREAMBLE_LEN = 32
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [4:0]  req_phy,
    input  logic [4:0]  req_reg,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mdc,
    output logic        mdio_oe,
    output logic        mdio_o,
    input  logic        mdio_i
);
    localparam int N  = PREAMBLE_LEN + 32;
    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PH_LAST  = PW'(CLK_DIV - 1);
    localparam logic [5:0]    LAST_BIT = 6'(N - 1);
    localparam logic [5:0]    TA2_BIT  = 6'(PREAMBLE_LEN + 15);

    typedef enum logic [2:0] {IDLE, PRE, CMD, TA, DATA} state_t;

    state_t        state;
    state_t        nxt_state;
    logic [PW-1:0] phase;
    logic [5:0]    bit_cnt;
    logic [5:0]    nb;
    int            nb_i;
    logic [31:0]   frame;
    logic [31:0]   new_frame;
    logic          is_write;
    logic [14:0]   shift;
    logic          ta_err;
    logic          nxt_o;
    logic          nxt_oe;

    // Post-preamble part of the frame; read TA/DATA slots hold 1 (bus released).
    always_comb begin
        new_frame = {2'b01, req_write ? 2'b01 : 2'b10, req_phy, req_reg,
                     req_write ? 2'b10 : 2'b11,
                     req_write ? req_wdata : 16'hFFFF};
        nb        = bit_cnt + 6'd1;
        nb_i      = int'(nb);
        nxt_o     = 1'b1;
        nxt_state = DATA;
        if (nb_i < PREAMBLE_LEN) begin
            nxt_state = PRE;
        end else begin
            nxt_o = frame[5'(31 + PREAMBLE_LEN - nb_i)];
            if (nb_i < PREAMBLE_LEN + 14)
                nxt_state = CMD;
            else if (nb_i < PREAMBLE_LEN + 16)
                nxt_state = TA;
        end
        nxt_oe = is_write || (nb_i < PREAMBLE_LEN + 14);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 16'h0;
            rsp_err   <= 1'b0;
            mdc       <= 1'b0;
            mdio_oe   <= 1'b0;
            mdio_o    <= 1'b1;
            phase     <= '0;
            bit_cnt   <= '0;
            frame     <= '0;
            is_write  <= 1'b0;
            shift     <= '0;
            ta_err    <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    mdc       <= 1'b0;
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        is_write  <= req_write;
                        frame     <= new_frame;
                        bit_cnt   <= '0;
                        phase     <= '0;
                        mdio_oe   <= 1'b1;
                        mdio_o    <= (PREAMBLE_LEN > 0) ? 1'b1 : new_frame[31];
                        state     <= (PREAMBLE_LEN > 0) ? PRE : CMD;
                    end
                end
                default: begin
                    if (phase == PH_LAST) begin
                        phase <= '0;
                        mdc   <= ~mdc;
                        // End of the high phase closes the current bit.
                        if (mdc) begin
                            if (state == TA && bit_cnt == TA2_BIT)
                                ta_err <= mdio_i;
                            if (state == DATA)
                                shift <= {shift[13:0], mdio_i};
                            if (bit_cnt == LAST_BIT) begin
                                state     <= IDLE;
                                req_ready <= 1'b1;
                                rsp_valid <= 1'b1;
                                mdio_oe   <= 1'b0;
                                mdio_o    <= 1'b1;
                                rsp_rdata <= is_write ? 16'h0 : {shift, mdio_i};
                                rsp_err   <= is_write ? 1'b0 : ta_err;
                            end else begin
                                bit_cnt <= nb;
                                state   <= nxt_state;
                                mdio_o  <= nxt_o;
                                mdio_oe <= nxt_oe;
                            end
                        end
                    end else begin
                        phase <= phase + PW'(1);
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mdio_master.sv
// Randomised scoreboard bench for mdio_master: per-cycle MDC/MDIO frame
// checking against a bit-list model plus a PHY model that answers reads.
module tb_mdio_master;
    localparam int D  = 2;
    localparam int P  = 32;
    localparam int N  = P + 32;
    localparam int FL = 2 * D * N;

    typedef struct {
        int          a;
        bit [63:0]   o;
        bit [63:0]   oe;
        bit [63:0]   drv;
        logic [15:0] rdata;
        bit          err;
    } exp_t;

    logic CLK = 0;
    logic RST = 1;
    always #5 CLK = ~CLK;

    logic        req_valid, req_ready, req_write;
    logic [4:0]  req_phy, req_reg;
    logic [15:0] req_wdata, rsp_rdata;
    logic        rsp_valid, rsp_err, mdc, mdio_oe, mdio_o, mdio_i;
    logic        phy_drv = 1'b1;

    logic        b_req_valid, b_req_ready, b_req_write;
    logic [4:0]  b_req_phy, b_req_reg;
    logic [15:0] b_req_wdata, b_rsp_rdata;
    logic        b_rsp_valid, b_rsp_err, b_mdc, b_mdio_oe, b_mdio_o, b_mdio_i;

    assign mdio_i   = mdio_oe ? mdio_o : phy_drv;
    assign b_mdio_i = b_mdio_oe ? b_mdio_o : 1'b1;

    mdio_master #(.CLK_DIV(D), .PREAMBLE_LEN(P)) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_phy(req_phy), .req_reg(req_reg), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mdc(mdc), .mdio_oe(mdio_oe), .mdio_o(mdio_o), .mdio_i(mdio_i)
    );

    mdio_master #(.CLK_DIV(1), .PREAMBLE_LEN(0)) dut_b (
        .CLK(CLK), .RST(RST),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
        .req_phy(b_req_phy), .req_reg(b_req_reg), .req_wdata(b_req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
        .mdc(b_mdc), .mdio_oe(b_mdio_oe), .mdio_o(b_mdio_o), .mdio_i(b_mdio_i)
    );

    int   pe = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   mon_on = 0;
    exp_t sb[$];

    always @(posedge CLK) pe++;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, pe);
        end
    endtask

    // Expected frame as a list of bits, preamble then fields MSB first.
    function automatic exp_t build(int p, bit wr, bit [4:0] phy, bit [4:0] rg,
                                   bit [15:0] wd, bit present, bit ta2,
                                   bit [15:0] rd, int a);
        exp_t e;
        int k;
        bit [31:0] f;
        e.a = a; e.o = '0; e.oe = '0; e.drv = '1;
        k = 0;
        for (int i = 0; i < p; i++) begin
            e.o[k] = 1; e.oe[k] = 1; k++;
        end
        f[31:30] = 2'b01;
        f[29:28] = wr ? 2'b01 : 2'b10;
        f[27:23] = phy;
        f[22:18] = rg;
        f[17:16] = wr ? 2'b10 : 2'b11;
        f[15:0]  = wr ? wd : 16'hFFFF;
        for (int i = 0; i < 32; i++) begin
            e.o[k]  = f[31-i];
            e.oe[k] = wr || (i < 14);
            if (!wr && present && i == 15) e.drv[k] = ta2;
            if (!wr && present && i >= 16) e.drv[k] = rd[31-i];
            k++;
        end
        e.rdata = wr ? 16'h0 : (present ? rd : 16'hFFFF);
        e.err   = wr ? 1'b0 : (present ? ta2 : 1'b1);
        return e;
    endfunction

    // Monitor: checks the pins each cycle against the front frame, drives PHY.
    always @(negedge CLK) begin
        int rel, k, ph;
        if (mon_on) begin
            if (sb.size() > 0 && pe >= sb[0].a) begin
                rel = pe - sb[0].a + 1;
                if (rel <= FL) begin
                    k  = (rel - 1) / (2 * D);
                    ph = (rel - 1) % (2 * D);
                    phy_drv = sb[0].drv[k];
                    chk("mdc", mdc, 32'(ph >= D));
                    chk("mdio_o", mdio_o, 32'(sb[0].o[k]));
                    chk("mdio_oe", mdio_oe, 32'(sb[0].oe[k]));
                    chk("rsp_valid_early", rsp_valid, 0);
                end else begin
                    phy_drv = 1'b1;
                    chk("rsp_valid", rsp_valid, 1);
                    chk("rsp_rdata", rsp_rdata, 32'(sb[0].rdata));
                    chk("rsp_err", rsp_err, 32'(sb[0].err));
                    chk("done_oe", mdio_oe, 0);
                    chk("done_o", mdio_o, 1);
                    chk("done_mdc", mdc, 0);
                    chk("done_ready", req_ready, 1);
                    void'(sb.pop_front());
                end
            end else begin
                phy_drv = 1'b1;
                chk("idle_rsp_valid", rsp_valid, 0);
                chk("idle_mdc", mdc, 0);
                chk("idle_oe", mdio_oe, 0);
            end
        end
    end

    task automatic send(bit wr, bit [4:0] phy, bit [4:0] rg, bit [15:0] wd,
                        bit present, bit ta2, bit [15:0] rd, output int a);
        int w;
        w = 0;
        req_write = wr; req_phy = phy; req_reg = rg; req_wdata = wd;
        req_valid = 1;
        while (!req_ready && w < 2000) begin
            @(posedge CLK); #1; w++;
        end
        if (!req_ready) begin
            chk("accept_timeout", 0, 1);
            req_valid = 0;
            a = -1;
            return;
        end
        a = pe + 1;
        sb.push_back(build(P, wr, phy, rg, wd, present, ta2, rd, a));
        @(posedge CLK); #1;
        req_valid = 0;
        req_write = 1'($urandom); req_phy = 5'($urandom);
        req_reg = 5'($urandom); req_wdata = 16'($urandom);
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb.size() > 0 && w < 3000) begin
            @(posedge CLK); #1; w++;
        end
        if (sb.size() > 0) begin
            chk("drain_timeout", 32'(sb.size()), 0);
            sb.delete();
        end
    endtask

    initial begin
        int a1, a2, ab;
        exp_t eb;
        req_valid = 0; req_write = 0; req_phy = 0; req_reg = 0; req_wdata = 0;
        b_req_valid = 0; b_req_write = 0; b_req_phy = 0; b_req_reg = 0;
        b_req_wdata = 0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_err", rsp_err, 0);
        chk("rst_mdc", mdc, 0);
        chk("rst_oe", mdio_oe, 0);
        chk("rst_o", mdio_o, 1);
        RST = 0;
        @(posedge CLK); #1;
        chk("ready_after_rst", req_ready, 1);
        mon_on = 1;

        send(1, 5'h01, 5'h04, 16'h1234, 1, 0, 0, a1);
        drain();
        send(0, 5'h1F, 5'h02, 0, 1, 0, 16'hBEEF, a1);
        drain();
        send(0, 5'h03, 5'h11, 0, 0, 0, 0, a1);
        drain();

        // Back-to-back: second request waits with valid held high.
        send(1, 5'h05, 5'h06, 16'hA5A5, 1, 0, 0, a1);
        send(0, 5'h07, 5'h08, 0, 1, 0, 16'h0F0F, a2);
        chk("b2b_accept_gap", 32'(a2 - a1), 32'(FL + 1));
        drain();

        // Reset in the middle of a write frame.
        send(1, 5'h0A, 5'h0B, 16'hC3C3, 1, 0, 0, a1);
        while (pe < a1 + 98) begin
            @(posedge CLK); #1;
        end
        RST = 1;
        @(posedge CLK); #1;
        sb.delete();
        chk("abort_mdc", mdc, 0);
        chk("abort_oe", mdio_oe, 0);
        chk("abort_o", mdio_o, 1);
        chk("abort_ready", req_ready, 0);
        chk("abort_rsp_valid", rsp_valid, 0);
        RST = 0;
        @(posedge CLK); #1;
        chk("abort_ready_back", req_ready, 1);
        send(1, 5'h12, 5'h13, 16'h5AA5, 1, 0, 0, a1);
        drain();

        for (int i = 0; i < 10; i++) begin
            bit wr, present, ta2, b2b;
            wr      = 1'($urandom);
            present = ($urandom % 4) != 0;
            ta2     = ($urandom % 4) == 0;
            b2b     = 1'($urandom);
            send(wr, 5'($urandom), 5'($urandom), 16'($urandom), present, ta2,
                 16'($urandom), a1);
            if (!b2b) begin
                drain();
                repeat ($urandom_range(0, 3)) @(posedge CLK);
                #1;
            end
        end
        drain();

        // No-preamble, divide-by-one instance: 32-bit frame, rsp at cycle 65.
        eb = build(0, 1, 5'h09, 5'h1C, 16'h8001, 1, 0, 0, 0);
        b_req_write = 1; b_req_phy = 5'h09; b_req_reg = 5'h1C;
        b_req_wdata = 16'h8001;
        chk("b_ready", b_req_ready, 1);
        b_req_valid = 1;
        @(posedge CLK); #1;
        b_req_valid = 0;
        ab = pe;
        for (int r = 1; r <= 65; r++) begin
            @(negedge CLK);
            if (pe - ab + 1 != r) chk("b_timing", 32'(pe - ab + 1), 32'(r));
            if (r <= 64) begin
                chk("b_mdc", b_mdc, 32'(((r - 1) % 2) == 1));
                chk("b_mdio_o", b_mdio_o, 32'(eb.o[(r - 1) / 2]));
                chk("b_mdio_oe", b_mdio_oe, 1);
                chk("b_rsp_valid_early", b_rsp_valid, 0);
            end else begin
                chk("b_rsp_valid", b_rsp_valid, 1);
                chk("b_rsp_rdata", b_rsp_rdata, 0);
                chk("b_rsp_err", b_rsp_err, 0);
                chk("b_done_oe", b_mdio_oe, 0);
            end
        end
        @(negedge CLK);
        chk("b_rsp_pulse", b_rsp_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mdio_master.md
Name: mdio_master

Overview:
- IEEE 802.3 Clause 22 MDIO management master; converts one-at-a-time register read/write requests into serial MDC/MDIO frames.
- Sits directly upstream of the generic tri-state pad buffer. mdio_oe drives the buffer's OE, mdio_o drives its I, and the buffer's O returns as mdio_i.
- Used by PHY-management workers in platform/device code.

Parameters:
- CLK_DIV, 10: CLK cycles per MDC half-period; legal range >= 1. Call this D.
- PREAMBLE_LEN, 32: number of preamble '1' bits; legal range 0..32 (0 = preamble suppression).

Ports:
- CLK  in  1  sole clock; every register is clocked on the rising edge.
- RST  in  1  synchronous reset, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; a transfer occurs when req_valid && req_ready.
- req_write  in  1  1 = write, 0 = read.
- req_phy  in  5  PHY address.
- req_reg  in  5  register address.
- req_wdata  in  16  write data; ignored for reads.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  16  read data; 0 for writes; held until the next rsp_valid.
- rsp_err  out  1  read turnaround error; 0 for writes; held until the next rsp_valid.
- mdc  out  1  management clock.
- mdio_oe  out  1  pad output enable.
- mdio_o  out  1  pad drive value.
- mdio_i  in  1  pad sampled value; an external pull-up makes the released bus read 1.

Behaviour:
- Reset (RST=1 on a rising edge) produces the following on the next cycle:
  - req_ready=0 while RST is held, then 1 from the first cycle after RST deasserts.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, mdc=0, mdio_oe=0, mdio_o=1.
  - State = IDLE.
- Reset mid-frame aborts the frame immediately. The bus is released, no rsp_valid is issued, and the request is discarded.
- On acceptance, the request fields are registered and req_ready drops the next cycle.
- State machine: IDLE -> PRE (PREAMBLE_LEN bits; skipped if 0) -> CMD (14 bits) -> TA (2 bits) -> DATA (16 bits) -> IDLE.
  - CMD bit order, MSB first: ST=01, OP (write 01 / read 10), PHY[4:0], REG[4:0].
  - Total frame length N = PREAMBLE_LEN + 32 bits.
- Bit timing, with cycle 0 = acceptance edge:
  - Bit k occupies cycles 1+2Dk .. 2D(k+1).
  - mdc=0 for the first D cycles of each bit and 1 for the last D cycles.
  - mdio_o/mdio_oe change only on the first cycle of a bit, i.e. coincident with the MDC falling transition.
  - mdc=0 in IDLE.
- Write frames:
  - mdio_oe=1 for all N bits.
  - TA drives 1 then 0.
  - DATA drives wdata MSB first.
- Read frames:
  - mdio_oe=1 through CMD; mdio_oe=0 for TA and DATA (18 bits), with mdio_o held at 1.
  - mdio_i is sampled on the last cycle of the high phase of the second TA bit and of each DATA bit.
  - A second TA sample of 1 sets rsp_err=1.
  - DATA samples shift in MSB first into rsp_rdata. rdata is still captured when err=1.
- Completion:
  - rsp_valid=1 for exactly one cycle, at cycle 1+2DN.
  - In that same cycle mdio_oe=0, mdio_o=1, mdc=0, state=IDLE and req_ready=1.
  - A request accepted in the rsp_valid cycle starts its frame on the next cycle; there is no idle gap.
- Counters:
  - A phase counter runs 0..D-1 and wraps, toggling mdc at each wrap.
  - A bit counter runs 0..N-1. No counter overflows at legal parameter values.
- Request inputs are ignored while req_ready=0.

Test Plan:
- D=2, PRE=32, write phy=0x01 reg=0x04 wdata=0x1234:
  - mdio_o per bit = 32x'1', 01, 01, 00001, 00100, 10, 0001001000110100.
  - mdio_oe=1 for cycles 1..256.
  - rsp_valid at cycle 257 with rdata=0, err=0; mdc period 4 cycles.
- D=2, read phy=0x1F reg=0x02 against a PHY model that drives TA=0 then 0xBEEF:
  - mdio_oe=0 for bits 46..63.
  - rsp_rdata=0xBEEF, rsp_err=0 at cycle 257.
- Read with no PHY attached (mdio_i constantly 1) -> rsp_rdata=0xFFFF, rsp_err=1.
- Assert RST at cycle 100 of a write for one cycle:
  - Next cycle shows mdc=0, mdio_oe=0, mdio_o=1; no rsp_valid ever.
  - The next request after reset produces a correct full frame.
- Back-to-back: second request held valid during the first frame:
  - Accepted exactly in the rsp_valid cycle (257).
  - Its first preamble bit appears at cycle 258; second rsp_valid at cycle 514.
- PREAMBLE_LEN=0, D=1, write:
  - First bit is ST '0'; frame is 32 bits.
  - rsp_valid at cycle 65.
